rcpu_uart_tx: RTL and testbench
===============================

RCPU_UART_TX -- requirements
Module: rcpu_uart_tx

Interface
REQ-001 The module SHALL have one clock, and its reset SHALL be asynchronous and active-high, named rst.
REQ-002 The module SHALL have parameter M, default 16, giving the data/address bus width.
REQ-003 The module SHALL have parameter BASE, default 16'hFF00, giving the TXDATA address; STATUS is at BASE+1.
REQ-004 The module SHALL have parameter CLKS_PER_BIT, default 16, giving the clock cycles per serial bit (legal range 2..65535).
REQ-005 The module SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The module SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 The module SHALL have port memAddr, input, M bits: CPU memory address.
REQ-008 The module SHALL have port memWrite, input, M bits: CPU write data.
REQ-009 The module SHALL have port memWE, input, 1 bit: CPU write enable.
REQ-010 The module SHALL have port rdData, output, M bits: read data, combinational from memAddr.
REQ-011 The module SHALL have port sel, output, 1 bit: high when memAddr equals BASE or BASE+1, so the top level can mux rdData onto memRead.
REQ-012 The module SHALL have port tx, output, 1 bit: registered serial line, idle high.

Function
REQ-013 The module SHALL hold a 4-entry, 8-bit FIFO with a 3-bit count (0..4); full is count==4 and empty is count==0, both evaluated on the pre-edge count.
REQ-014 A write SHALL push memWrite[7:0] at the edge when memWE=1, memAddr=BASE, and the FIFO is not full; memWrite[M-1:8] SHALL be ignored.
REQ-015 A write to TXDATA while full SHALL be dropped even if a pop occurs on the same edge, and it SHALL set sticky flag ovf.
REQ-016 A write to BASE+1 with memWrite[6]=1 SHALL clear ovf; if a drop occurs on the same edge, the set SHALL win.
REQ-017 A simultaneous push and pop SHALL leave count unchanged, with FIFO order preserved.
REQ-018 rdData SHALL be {0..., ovf, count[2:0], empty, full, busy} (bits 6..0) at BASE+1, and 0 at BASE or when sel=0.
REQ-019 The TX FSM SHALL have states IDLE, START, DATA, and STOP; busy SHALL be high whenever state!=IDLE.
REQ-020 In IDLE with the FIFO non-empty, the FSM SHALL on the next edge pop the head into the shift register, load the bit counter to CLKS_PER_BIT-1, set tx=0, and enter START.
REQ-021 In START, after CLKS_PER_BIT cycles of tx=0, the FSM SHALL drive tx=shift[0], enter DATA, and set the bit index to 0.
REQ-022 In DATA, each bit SHALL be held CLKS_PER_BIT cycles, LSB first; after bit 7 the FSM SHALL drive tx=1 and enter STOP.
REQ-023 STOP SHALL last CLKS_PER_BIT cycles; at its end the FSM SHALL pop and enter START directly (tx=0) if the FIFO is non-empty, or otherwise enter IDLE.
REQ-024 A frame SHALL be exactly 10*CLKS_PER_BIT cycles, and back-to-back frames SHALL have no idle gap.
REQ-025 The baud counter SHALL be a down-counter of at least 16 bits that reloads to CLKS_PER_BIT-1 on every bit boundary, with no drift across frames.
REQ-026 A write with memWE=0, or to any address other than BASE or BASE+1, SHALL have no effect.

Reset
REQ-027 While rst=1, and immediately on its assertion, tx SHALL be 1, state SHALL be IDLE, count 0, ovf 0, and the baud counter and bit index 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame and discard all FIFO contents.
REQ-029 The first push SHALL be accepted at the first rising edge after rst deasserts.

Verification (CLKS_PER_BIT=4, BASE=16'hFF00)
REQ-030 Write 0x55 to FF00 -> tx reads 0 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles; busy high for 40 cycles.
REQ-031 Write 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles -> 0x01 popped, 0x02..0x05 accepted, and the STATUS read shows count=4, full=1, ovf=0; with one write per cycle while full, the next write is dropped and ovf=1.
REQ-032 Queue two bytes -> the second start bit begins exactly 40 cycles after the first start bit; writing 0x40 to FF01 then clears ovf.
REQ-033 Assert rst at cycle 13 of a frame -> tx=1 in the same cycle, STATUS reads 0x04 (empty) after reset, and no further tx activity occurs.
REQ-034 memAddr=FF02 -> sel=0 and rdData=0; a write to FF00 with memWE=0 -> count stays 0.
REQ-035 A random push stream against a scoreboard -> the serialized bytes match the accepted writes in order, and the drop count matches ovf events.

Source files
------------

// File: rtl/rcpu_uart_tx_if.sv
// rcpu_uart_tx_if: CPU memory bus as seen by a memory-mapped peripheral.
// master drives address/data/enable, slave returns read data and select.
interface rcpu_uart_tx_if #(
    parameter int M = 16
);
    logic [M-1:0] memAddr;
    logic [M-1:0] memWrite;
    logic         memWE;
    logic [M-1:0] rdData;
    logic         sel;

    modport master (
        output memAddr,
        output memWrite,
        output memWE,
        input  rdData,
        input  sel
    );

    modport slave (
        input  memAddr,
        input  memWrite,
        input  memWE,
        output rdData,
        output sel
    );
endinterface

// File: rtl/rcpu_uart_tx.sv
// rcpu_uart_tx: memory-mapped 8N1 UART transmitter with a 4-deep FIFO.
// TXDATA sits at BASE, STATUS at BASE+1.
module rcpu_uart_tx #(
    parameter int           M            = 16,
    parameter logic [M-1:0] BASE         = 16'hFF00,
    parameter int           CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    rcpu_uart_tx_if.slave bus,
    output logic          tx
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } txState_t;

    localparam logic [M-1:0] statAddr =
        BASE + {{(M-1){1'b0}}, 1'b1};
    localparam logic [15:0] baudLoad =
        16'(CLKS_PER_BIT - 1);

    logic [7:0]  fifoMem [4];
    logic [1:0]  wrPtr;
    logic [1:0]  rdPtr;
    logic [2:0]  count;
    logic        ovf;

    logic        full;
    logic        empty;
    logic        dataHit;
    logic        statHit;
    logic        push;
    logic        drop;
    logic        ovfClr;
    logic        pop;
    logic        busy;
    logic [7:0]  headData;

    txState_t    state;
    txState_t    stateNext;
    logic [15:0] baudCnt;
    logic [15:0] baudNext;
    logic [2:0]  bitIdx;
    logic [2:0]  bitNext;
    logic [7:0]  shiftReg;
    logic [7:0]  shiftNext;
    logic        txReg;
    logic        txNext;

    assign full     = (count == 3'd4);
    assign empty    = (count == 3'd0);
    assign dataHit  = (bus.memAddr == BASE);
    assign statHit  = (bus.memAddr == statAddr);
    assign push     = bus.memWE && dataHit && !full;
    assign drop     = bus.memWE && dataHit && full;
    assign ovfClr   = bus.memWE && statHit
                    && bus.memWrite[6];
    assign busy     = (state != IDLE);
    assign headData = fifoMem[rdPtr];
    assign tx       = txReg;

    assign bus.sel  = dataHit || statHit;

    always_comb begin
        bus.rdData = '0;
        if (statHit) begin
            bus.rdData[6:0] =
                {ovf, count, empty, full, busy};
        end
    end

    // A full FIFO drops the write even if the
    // transmitter frees a slot on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                fifoMem[i] <= 8'h00;
            end
            wrPtr <= 2'd0;
            rdPtr <= 2'd0;
            count <= 3'd0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                fifoMem[wrPtr] <= bus.memWrite[7:0];
                wrPtr          <= wrPtr + 2'd1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 2'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovfClr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baudCnt  <= 16'd0;
            bitIdx   <= 3'd0;
            shiftReg <= 8'h00;
            txReg    <= 1'b1;
        end else begin
            state    <= stateNext;
            baudCnt  <= baudNext;
            bitIdx   <= bitNext;
            shiftReg <= shiftNext;
            txReg    <= txNext;
        end
    end

    // The shift register moves right once per data
    // bit, so the next bit to send is always shiftReg[1].
    always_comb begin
        stateNext = state;
        baudNext  = baudCnt;
        bitNext   = bitIdx;
        shiftNext = shiftReg;
        txNext    = txReg;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shiftNext = headData;
                    baudNext  = baudLoad;
                    txNext    = 1'b0;
                    stateNext = START;
                end
            end
            START: begin
                if (baudCnt == 16'd0) begin
                    baudNext  = baudLoad;
                    bitNext   = 3'd0;
                    txNext    = shiftReg[0];
                    stateNext = DATA;
                end else begin
                    baudNext = baudCnt - 16'd1;
                end
            end
            DATA: begin
                if (baudCnt == 16'd0) begin
                    baudNext = baudLoad;
                    if (bitIdx == 3'd7) begin
                        txNext    = 1'b1;
                        stateNext = STOP;
                    end else begin
                        bitNext   = bitIdx + 3'd1;
                        shiftNext = {1'b0, shiftReg[7:1]};
                        txNext    = shiftReg[1];
                    end
                end else begin
                    baudNext = baudCnt - 16'd1;
                end
            end
            STOP: begin
                if (baudCnt == 16'd0) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        shiftNext = headData;
                        baudNext  = baudLoad;
                        txNext    = 1'b0;
                        stateNext = START;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    baudNext = baudCnt - 16'd1;
                end
            end
            default: begin
                stateNext = IDLE;
                txNext    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_rcpu_uart_tx.sv
// tb_rcpu_uart_tx: directed vectors, frame checks and a scoreboard
// for the UART transmitter with CLKS_PER_BIT=4, BASE=FF00.
module tb_rcpu_uart_tx;

    logic clk;
    logic rst;
    logic tx;

    rcpu_uart_tx_if #(.M(16)) bus();

    rcpu_uart_tx #(
        .M(16),
        .BASE(16'hFF00),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nPass;
    int nTotal;
    int cyc;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        we;
        logic        expSel;
        logic [15:0] expRd;
    } vec_t;

    vec_t vecs[8];

    logic [7:0] expQ[$];
    logic [7:0] rxQ[$];
    int         startQ[$];
    int         frErr;

    // Independent serial receiver: samples mid-bit.
    logic       rxBusy;
    logic [5:0] rxCnt;
    logic [7:0] rxShift;

    always @(negedge clk) begin
        if (rst) begin
            rxBusy <= 1'b0;
        end else if (!rxBusy) begin
            if (tx == 1'b0) begin
                rxBusy <= 1'b1;
                rxCnt  <= 6'd1;
                startQ.push_back(cyc);
            end
        end else begin
            if (rxCnt[1:0] == 2'd2) begin
                if (rxCnt[5:2] >= 4'd1 && rxCnt[5:2] <= 4'd8) begin
                    rxShift[3'(rxCnt[5:2] - 4'd1)] <= tx;
                end else if (rxCnt[5:2] == 4'd9) begin
                    if (tx !== 1'b1) frErr <= frErr + 1;
                    rxQ.push_back(rxShift);
                end
            end
            if (rxCnt == 6'd39) rxBusy <= 1'b0;
            else rxCnt <= rxCnt + 6'd1;
        end
    end

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        nTotal++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h",
                      name, got, exp);
    endtask

    task automatic busWrite(input logic [15:0] a,
                            input logic [15:0] d);
        bus.memAddr  = a;
        bus.memWrite = d;
        bus.memWE    = 1'b1;
        @(negedge clk);
        bus.memWE    = 1'b0;
        bus.memAddr  = 16'hFF01;
        bus.memWrite = 16'h0000;
    endtask

    function automatic logic expBit(input logic [7:0] d,
                                    input int k);
        int s;
        s = (k - 1) / 4;
        if (s == 0) return 1'b0;
        if (s <= 8) return d[3'(s - 1)];
        return 1'b1;
    endfunction

    task automatic expectFrame(input logic [7:0] d);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("frame%0h_tx%0d", d, k),
                32'(tx), 32'(expBit(d, k)));
            chk($sformatf("frame%0h_busy%0d", d, k),
                32'(bus.rdData[0]), 32'd1);
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        bus.memAddr = 16'hFF01;
        bus.memWE   = 1'b0;
        @(negedge clk);
        #1;
        while (!(bus.rdData[0] == 1'b0 && bus.rdData[2] == 1'b1)
               && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, 32'(n < 1000), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int bStart;
        int quietBad;
        int mCount;
        int mTimer;
        logic mBusy;
        logic mOvf;
        logic popNow;
        logic doW;
        logic [7:0] wd;

        nPass = 0;
        nTotal = 0;
        cyc = 0;
        frErr = 0;
        rxBusy = 1'b0;
        rxCnt = 6'd0;
        rxShift = 8'h00;

        vecs[0] = '{16'hFF02, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{16'hFF01, 16'h0000, 1'b0, 1'b1, 16'h0004};
        vecs[2] = '{16'hFF00, 16'h0099, 1'b0, 1'b1, 16'h0000};
        vecs[3] = '{16'hFF01, 16'h0000, 1'b0, 1'b1, 16'h0004};
        vecs[4] = '{16'hFF03, 16'h0012, 1'b1, 1'b0, 16'h0000};
        vecs[5] = '{16'hFEFF, 16'h0034, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{16'hFF01, 16'h0040, 1'b1, 1'b1, 16'h0004};
        vecs[7] = '{16'hFF01, 16'h0000, 1'b0, 1'b1, 16'h0004};

        rst = 1'b1;
        bus.memAddr  = 16'hFF01;
        bus.memWrite = 16'h0000;
        bus.memWE    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("resetTx", 32'(tx), 32'd1);
        chk("resetStat", 32'(bus.rdData), 32'h04);
        chk("resetSel", 32'(bus.sel), 32'd1);
        rst = 1'b0;

        // Decode and no-effect writes
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.memAddr  = vecs[i].addr;
            bus.memWrite = vecs[i].data;
            bus.memWE    = vecs[i].we;
            #1;
            chk($sformatf("vec%0d_sel", i),
                32'(bus.sel), 32'(vecs[i].expSel));
            chk($sformatf("vec%0d_rd", i),
                32'(bus.rdData), 32'(vecs[i].expRd));
        end
        @(negedge clk);
        bus.memWE = 1'b0;
        bus.memAddr = 16'hFF01;
        #1;
        chk("vecEndStat", 32'(bus.rdData), 32'h04);
        chk("vecEndTx", 32'(tx), 32'd1);

        // Single frame 0x55
        busWrite(16'hFF00, 16'hAB55);
        expQ.push_back(8'h55);
        #1;
        chk("a_queued", 32'(bus.rdData), 32'h08);
        chk("a_txIdle", 32'(tx), 32'd1);
        expectFrame(8'h55);
        @(negedge clk);
        #1;
        chk("a_doneBusy", 32'(bus.rdData[0]), 32'd0);
        chk("a_doneTx", 32'(tx), 32'd1);

        // Fill, overflow, clear, drop-with-pop
        bStart = startQ.size();
        for (int i = 1; i <= 5; i++) begin
            busWrite(16'hFF00, 16'(i));
            expQ.push_back(8'(i));
        end
        #1;
        chk("b_full", 32'(bus.rdData), 32'h23);
        busWrite(16'hFF00, 16'h0006);
        #1;
        chk("b_drop", 32'(bus.rdData), 32'h63);
        busWrite(16'hFF01, 16'h0040);
        #1;
        chk("b_clear", 32'(bus.rdData), 32'h23);
        repeat (34) @(negedge clk);
        busWrite(16'hFF00, 16'h0007);
        #1;
        chk("b_dropPop", 32'(bus.rdData), 32'h59);
        busWrite(16'hFF01, 16'h0040);
        #1;
        chk("b_clear2", 32'(bus.rdData), 32'h19);
        busWrite(16'hFF00, 16'h0008);
        expQ.push_back(8'h08);
        #1;
        chk("b_refill", 32'(bus.rdData), 32'h23);
        waitIdle("b_drain");
        if (startQ.size() >= bStart + 6) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("b_gap%0d", i),
                    32'(startQ[bStart + i + 1] - startQ[bStart + i]),
                    32'd40);
            end
        end else begin
            chk("b_frames", 32'(startQ.size() - bStart), 32'd6);
        end

        // Reset mid-frame
        busWrite(16'hFF00, 16'h00A5);
        busWrite(16'hFF00, 16'h0011);
        busWrite(16'hFF00, 16'h0022);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("c_rstTx", 32'(tx), 32'd1);
        chk("c_rstStat", 32'(bus.rdData), 32'h04);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        quietBad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (tx !== 1'b1 || bus.rdData !== 16'h0004) quietBad++;
        end
        chk("c_quiet", 32'(quietBad), 32'd0);

        // First edge after reset release accepts a push
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        busWrite(16'hFF00, 16'h003C);
        expQ.push_back(8'h3C);
        #1;
        chk("c_firstPush", 32'(bus.rdData), 32'h08);
        waitIdle("c_drain");

        // Random stream against a behavioural model
        mCount = 0;
        mTimer = 0;
        mBusy = 1'b0;
        mOvf = 1'b0;
        for (int i = 0; i < 150; i++) begin
            doW = ($urandom_range(0, 3) != 0);
            wd = 8'($urandom_range(0, 255));
            bus.memAddr  = 16'hFF00;
            bus.memWrite = {8'($urandom_range(0, 255)), wd};
            bus.memWE    = doW;
            popNow = 1'b0;
            if (!mBusy) begin
                if (mCount > 0) begin
                    popNow = 1'b1;
                    mBusy = 1'b1;
                    mTimer = 0;
                end
            end else begin
                mTimer++;
                if (mTimer == 40) begin
                    if (mCount > 0) begin
                        popNow = 1'b1;
                        mTimer = 0;
                    end else begin
                        mBusy = 1'b0;
                    end
                end
            end
            if (doW && mCount == 4) begin
                mOvf = 1'b1;
            end else if (doW) begin
                expQ.push_back(wd);
                mCount++;
            end
            if (popNow) mCount--;
            @(negedge clk);
        end
        bus.memWE = 1'b0;
        waitIdle("d_drain");
        chk("d_ovf", 32'(bus.rdData[6]), 32'(mOvf));
        chk("d_count", 32'(bus.rdData[5:3]), 32'd0);

        chk("sb_size", 32'(rxQ.size()), 32'(expQ.size()));
        for (int i = 0; i < rxQ.size() && i < expQ.size(); i++) begin
            chk($sformatf("sb_byte%0d", i),
                32'(rxQ[i]), 32'(expQ[i]));
        end
        chk("sb_framing", 32'(frErr), 32'd0);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
